// File: rtl/ysyx_23060286_regfile_mp_pkg.sv
// Shared constants and the highest-index-wins write select for the multi-port register file.
// The bypass feature is enabled by defining YSYX_23060286_RF_BYPASS_EN.
package ysyx_23060286_rf_pkg;

  localparam int RF_XLEN   = 32;
  localparam int RF_NREG   = 32;
  localparam int REG_ZERO  = 0;
  localparam int MAX_PORTS = 16;

  typedef struct packed {
    logic       hit;
    logic [3:0] idx;
  } wsel_t;

  // Later ports overwrite earlier ones, so the highest matching port is returned.
  function automatic wsel_t wr_select(input logic [MAX_PORTS-1:0] match);
    wsel_t sel;
    sel = '0;
    for (int i = 0; i < MAX_PORTS; i++) begin
      if (match[i]) begin
        sel.hit = 1'b1;
        sel.idx = 4'(i);
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/ysyx_23060286_regfile_mp_if.sv
// Bus interface for the multi-port register file: write ports, read ports, issue and scoreboard view.
// The bypass feature is enabled by defining YSYX_23060286_RF_BYPASS_EN.
interface ysyx_23060286_regfile_mp_if
  import ysyx_23060286_rf_pkg::*;
#(
  parameter int XLEN = RF_XLEN,
  parameter int NREG = RF_NREG,
  parameter int NRD  = 2,
  parameter int NWR  = 2
) ();

  localparam int AW = $clog2(NREG);

  logic [NWR-1:0]      wen;
  logic [NWR*AW-1:0]   waddr;
  logic [NWR*XLEN-1:0] wdata;
  logic [NRD*AW-1:0]   raddr;
  logic [NRD*XLEN-1:0] rdata;
  logic [NRD-1:0]      rbusy;
  logic                issue_en;
  logic [AW-1:0]       issue_addr;
  logic [NREG-1:0]     busy_vec;

  modport master (
    output wen, waddr, wdata, raddr, issue_en, issue_addr,
    input  rdata, rbusy, busy_vec
  );

  modport slave (
    input  wen, waddr, wdata, raddr, issue_en, issue_addr,
    output rdata, rbusy, busy_vec
  );

endinterface

// File: rtl/ysyx_23060286_regfile_mp_scoreboard.sv
// Busy scoreboard: one bit per register, set on issue, cleared on writeback, looked up per read port.
// With YSYX_23060286_RF_BYPASS_EN defined, a same-cycle writeback hides the busy bit from readers.
module ysyx_23060286_rf_scoreboard
  import ysyx_23060286_rf_pkg::*;
#(
  parameter int NREG = RF_NREG,
  parameter int AW   = $clog2(NREG),
  parameter int NRD  = 2,
  parameter int NWR  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NWR-1:0]    wen_i,
  input  logic [NWR*AW-1:0] waddr_i,
  input  logic [NRD*AW-1:0] raddr_i,
  input  logic              issue_en_i,
  input  logic [AW-1:0]     issue_addr_i,
  output logic [NRD-1:0]    rbusy_o,
  output logic [NREG-1:0]   busy_vec_o
);

  logic [NREG-1:0] busy_q, busy_d;

  // Clears are applied first so a new producer issued this cycle keeps its register busy.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NWR; i++) begin
      if (wen_i[i]) busy_d[waddr_i[i*AW +: AW]] = 1'b0;
    end
    if (issue_en_i) busy_d[issue_addr_i] = 1'b1;
    busy_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  always_comb begin
    logic [AW-1:0]        a;
    logic [MAX_PORTS-1:0] m;
    wsel_t                sel;
    rbusy_o = '0;
    for (int j = 0; j < NRD; j++) begin
      a   = raddr_i[j*AW +: AW];
      m   = '0;
      sel = '0;
      rbusy_o[j] = busy_q[a];
`ifdef YSYX_23060286_RF_BYPASS_EN
      for (int i = 0; i < NWR; i++) m[i] = wen_i[i] && (waddr_i[i*AW +: AW] == a);
      sel = wr_select(m);
      if (sel.hit && !(issue_en_i && issue_addr_i == a)) rbusy_o[j] = 1'b0;
`endif
    end
  end

  assign busy_vec_o = busy_q;

endmodule

// File: rtl/ysyx_23060286_regfile_mp.sv
// Multi-port integer register file (NWR writes, NRD reads) with a RAW busy scoreboard; x0 reads zero.
// Define YSYX_23060286_RF_BYPASS_EN to forward same-cycle writes to the read ports.
module ysyx_23060286_regfile_mp
  import ysyx_23060286_rf_pkg::*;
#(
  parameter int XLEN = RF_XLEN,
  parameter int NREG = RF_NREG,
  parameter int NRD  = 2,
  parameter int NWR  = 2
) (
  input logic clk,
  input logic rst_n,
  ysyx_23060286_regfile_mp_if.slave bus
);

  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0] rf_q [NREG];
  logic [XLEN-1:0] rf_d [NREG];

  always_comb begin
    logic [MAX_PORTS-1:0] m;
    wsel_t                sel;
    for (int r = 0; r < NREG; r++) begin
      m = '0;
      for (int i = 0; i < NWR; i++) m[i] = bus.wen[i] && (bus.waddr[i*AW +: AW] == AW'(r));
      sel     = wr_select(m);
      rf_d[r] = sel.hit ? bus.wdata[int'(sel.idx)*XLEN +: XLEN] : rf_q[r];
    end
    rf_d[REG_ZERO] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) rf_q[r] <= '0;
    end else begin
      rf_q <= rf_d;
    end
  end

  always_comb begin
    logic [AW-1:0]        a;
    logic [MAX_PORTS-1:0] m;
    wsel_t                sel;
    bus.rdata = '0;
    for (int j = 0; j < NRD; j++) begin
      a   = bus.raddr[j*AW +: AW];
      m   = '0;
      sel = '0;
      bus.rdata[j*XLEN +: XLEN] = (a == AW'(REG_ZERO)) ? '0 : rf_q[a];
`ifdef YSYX_23060286_RF_BYPASS_EN
      for (int i = 0; i < NWR; i++) m[i] = bus.wen[i] && (bus.waddr[i*AW +: AW] == a);
      sel = wr_select(m);
      if (sel.hit && a != AW'(REG_ZERO)) bus.rdata[j*XLEN +: XLEN] = bus.wdata[int'(sel.idx)*XLEN +: XLEN];
`endif
    end
  end

  ysyx_23060286_rf_scoreboard #(
    .NREG (NREG),
    .AW   (AW),
    .NRD  (NRD),
    .NWR  (NWR)
  ) u_scoreboard (
    .clk          (clk),
    .rst_n        (rst_n),
    .wen_i        (bus.wen),
    .waddr_i      (bus.waddr),
    .raddr_i      (bus.raddr),
    .issue_en_i   (bus.issue_en),
    .issue_addr_i (bus.issue_addr),
    .rbusy_o      (bus.rbusy),
    .busy_vec_o   (bus.busy_vec)
  );

endmodule

// File: tb/tb_ysyx_23060286_regfile_mp.sv
// Self-checking bench for ysyx_23060286_regfile_mp in the wide configuration (4 read, 3 write, 64x64).
// Expectations follow YSYX_23060286_RF_BYPASS_EN when it is defined for the build.
module tb_ysyx_23060286_regfile_mp;

  localparam int XLEN = 64;
  localparam int NREG = 64;
  localparam int NRD  = 4;
  localparam int NWR  = 3;
  localparam int AW   = 6;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ysyx_23060286_regfile_mp_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) bus ();

  ysyx_23060286_regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [XLEN-1:0] modelRf [NREG];
  bit              modelBusy [NREG];
  int vectors     = 0;
  int miscompares = 0;

  task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic resetModel();
    for (int r = 0; r < NREG; r++) begin
      modelRf[r]   = '0;
      modelBusy[r] = 1'b0;
    end
  endtask

  task automatic clearInputs();
    bus.wen        = '0;
    bus.waddr      = '0;
    bus.wdata      = '0;
    bus.raddr      = '0;
    bus.issue_en   = 1'b0;
    bus.issue_addr = '0;
  endtask

  task automatic setWrite(input int p, input int a, input logic [XLEN-1:0] d);
    bus.wen[p]                 = 1'b1;
    bus.waddr[p*AW +: AW]      = AW'(a);
    bus.wdata[p*XLEN +: XLEN]  = d;
  endtask

  task automatic setRead(input int p, input int a);
    bus.raddr[p*AW +: AW] = AW'(a);
  endtask

  task automatic setIssue(input int a);
    bus.issue_en   = 1'b1;
    bus.issue_addr = AW'(a);
  endtask

  // Matching writes are scanned in port order, so the last hit is the highest-indexed port.
  function automatic logic [XLEN-1:0] expRead(input int a);
    logic [XLEN-1:0] v;
    v = (a == 0) ? '0 : modelRf[a];
`ifdef YSYX_23060286_RF_BYPASS_EN
    for (int i = 0; i < NWR; i++)
      if (a != 0 && bus.wen[i] && int'(bus.waddr[i*AW +: AW]) == a) v = bus.wdata[i*XLEN +: XLEN];
`endif
    return v;
  endfunction

  function automatic logic expBusy(input int a);
    logic b;
    b = modelBusy[a];
`ifdef YSYX_23060286_RF_BYPASS_EN
    for (int i = 0; i < NWR; i++)
      if (bus.wen[i] && int'(bus.waddr[i*AW +: AW]) == a && !(bus.issue_en && int'(bus.issue_addr) == a))
        b = 1'b0;
`endif
    return b;
  endfunction

  task automatic checkOutput();
    logic [NREG-1:0] bv;
    int a;
    for (int j = 0; j < NRD; j++) begin
      a = int'(bus.raddr[j*AW +: AW]);
      compare($sformatf("rdata[%0d] addr %0d", j, a), bus.rdata[j*XLEN +: XLEN], expRead(a));
      compare($sformatf("rbusy[%0d] addr %0d", j, a), 64'(bus.rbusy[j]), 64'(expBusy(a)));
    end
    for (int r = 0; r < NREG; r++) bv[r] = modelBusy[r];
    compare("busy_vec", bus.busy_vec, bv);
  endtask

  task automatic updateModel();
    int a;
    for (int i = 0; i < NWR; i++) begin
      a = int'(bus.waddr[i*AW +: AW]);
      if (bus.wen[i] && a != 0) begin
        modelRf[a]   = bus.wdata[i*XLEN +: XLEN];
        modelBusy[a] = 1'b0;
      end
    end
    if (bus.issue_en && bus.issue_addr != '0) modelBusy[int'(bus.issue_addr)] = 1'b1;
  endtask

  // Called just after a falling edge with inputs set; returns at the next falling edge, inputs idle.
  task automatic step();
    #1 checkOutput();
    @(posedge clk);
    updateModel();
    @(negedge clk);
    clearInputs();
  endtask

  function automatic int pickAddr();
    return ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, NREG-1));
  endfunction

  task automatic applyStimulus();
    for (int i = 0; i < NWR; i++) begin
      bus.wen[i]                = 1'($urandom_range(0, 1));
      bus.waddr[i*AW +: AW]     = AW'(pickAddr());
      bus.wdata[i*XLEN +: XLEN] = {$urandom, $urandom};
    end
    for (int j = 0; j < NRD; j++) begin
      if ($urandom_range(0, 3) == 0)
        bus.raddr[j*AW +: AW] = bus.waddr[int'($urandom_range(0, NWR-1))*AW +: AW];
      else
        bus.raddr[j*AW +: AW] = AW'(pickAddr());
    end
    bus.issue_en   = ($urandom_range(0, 2) == 0);
    bus.issue_addr = AW'(pickAddr());
  endtask

  initial begin
    clearInputs();
    resetModel();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    setRead(0, 5);
    #1;
    compare("reset rdata", bus.rdata[0 +: XLEN], 64'h0);
    compare("reset busy_vec", bus.busy_vec, 64'h0);
    rst_n = 1'b1;
    step();

    // Asynchronous reset in the middle of a cycle, with a write pending that must be discarded.
    setWrite(0, 5, 64'h1234);
    setIssue(5);
    step();
    setRead(0, 5);
    setRead(1, 6);
    setWrite(1, 6, 64'h6666);
    #1;
    compare("pre-reset rdata r5", bus.rdata[0 +: XLEN], 64'h1234);
    compare("pre-reset busy r5", 64'(bus.busy_vec[5]), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    compare("async reset rdata r5", bus.rdata[0 +: XLEN], 64'h0);
    compare("async reset busy_vec", bus.busy_vec, 64'h0);
    resetModel();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clearInputs();
    setRead(1, 6);
    #1 compare("write during reset discarded", bus.rdata[XLEN +: XLEN], 64'h0);
    step();

    setWrite(0, 0, 64'hDEADBEEF);
    setIssue(0);
    step();
    setRead(0, 0);
    #1;
    compare("x0 reads zero", bus.rdata[0 +: XLEN], 64'h0);
    compare("x0 never busy", 64'(bus.busy_vec[0]), 64'h0);
    step();

    setWrite(0, 7, 64'h11);
    setWrite(1, 7, 64'h22);
    step();
    setRead(0, 7);
    #1 compare("collision p1 wins", bus.rdata[0 +: XLEN], 64'h22);
    setWrite(0, 7, 64'h44);
    setWrite(2, 7, 64'h33);
    step();
    setRead(2, 7);
    #1 compare("collision p2 wins", bus.rdata[2*XLEN +: XLEN], 64'h33);
    step();

    setIssue(9);
    step();
    setRead(0, 9);
    #1 compare("issue sets rbusy", 64'(bus.rbusy[0]), 64'h1);
    setIssue(9);
    setWrite(0, 9, 64'h99);
    step();
    #1 compare("set beats clear", 64'(bus.busy_vec[9]), 64'h1);
    setWrite(1, 9, 64'hAA);
    step();
    #1 compare("write clears busy", 64'(bus.busy_vec[9]), 64'h0);
    step();

    setWrite(0, 3, 64'h1111);
    setIssue(3);
    step();
    setWrite(1, 3, 64'hCAFE);
    setRead(1, 3);
    #1;
`ifdef YSYX_23060286_RF_BYPASS_EN
    compare("bypass rdata same cycle", bus.rdata[XLEN +: XLEN], 64'hCAFE);
    compare("bypass rbusy same cycle", 64'(bus.rbusy[1]), 64'h0);
`else
    compare("no bypass old rdata", bus.rdata[XLEN +: XLEN], 64'h1111);
    compare("no bypass rbusy held", 64'(bus.rbusy[1]), 64'h1);
`endif
    step();
    setRead(1, 3);
    #1;
    compare("write visible next cycle", bus.rdata[XLEN +: XLEN], 64'hCAFE);
    compare("busy cleared next cycle", 64'(bus.rbusy[1]), 64'h0);
    step();

    repeat (10000) begin
      applyStimulus();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ysyx_23060286_regfile_mp.md
Name: ysyx_23060286_regfile_mp

Overview:
Parametrised multi-port integer register file with an integrated busy scoreboard. It replaces the single-write, two-read file in the decode/writeback path so the core can retire NWR results per cycle and read NRD operands per cycle. The scoreboard tracks registers with an in-flight producer so issue logic can stall on RAW hazards. Entry 0 is hardwired to zero and never reports busy.

Parameters:
XLEN, 32, data width in bits
NREG, 32, number of architectural registers (power of 2, ≥2)
AW, $clog2(NREG), register address width (derived; do not override)
NRD, 2, number of read ports
NWR, 2, number of write ports

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
wen  in  NWR  per-port write enable
waddr  in  NWR*AW  write addresses, port i at [i*AW +: AW]
wdata  in  NWR*XLEN  write data, port i at [i*XLEN +: XLEN]
raddr  in  NRD*AW  read addresses
rdata  out  NRD*XLEN  read data
rbusy  out  NRD  per read port: addressed register has an in-flight producer
issue_en  in  1  mark issue_addr busy (instruction with destination issued)
issue_addr  in  AW  destination being issued
busy_vec  out  NREG  full scoreboard, for debug/commit checks

Behaviour:
- Reset (rst_n low, asynchronous): all NREG entries ← 0; all busy bits ← 0; rdata reads 0; rbusy = 0. Reset deassertion is taken synchronously to clk by the integrating module. Reset asserted mid-write discards the write.
- Writes: on posedge clk, for each port i with wen[i] and waddr[i] ≠ 0: rf[waddr[i]] ← wdata[i].
- Same-address collision: if several ports write the same address in one cycle, the highest-indexed port wins.
- Writes to address 0 are ignored. rf[0] always reads 0.
- Reads: combinational; rdata port j = rf[raddr[j]], with raddr = 0 → 0. Zero cycles of latency from the stored state.
- Scoreboard, evaluated at posedge clk:
  - issue_en with issue_addr ≠ 0 sets busy[issue_addr].
  - Any wen[i] with waddr[i] ≠ 0 clears busy[waddr[i]].
  - If a set and a clear target the same address in the same cycle, the set wins (a new producer supersedes the completing one).
  - issue_en with issue_addr = 0 is ignored.
  - busy[0] is always 0.
- rbusy[j] = busy[raddr[j]], modified by the optional feature below.
- busy_vec reflects the registered busy bits only; it is never bypassed.
- Address width: addresses are AW bits, so NREG being a power of 2 means no out-of-range addresses exist.

Optional Feature:
Macro: YSYX_23060286_RF_BYPASS_EN.
- Defined:
  - Write-to-read forwarding. If any wen[i] with waddr[i] = raddr[j] ≠ 0 in the current cycle, rdata[j] = wdata of the winning (highest-indexed) matching port.
  - rbusy[j] is forced to 0 when such a matching write exists and no same-cycle issue_en targets raddr[j].
  - Combinational path from wdata/waddr to rdata.
- Undefined:
  - Reads return stored state only; a write is visible from the next cycle.
  - rbusy[j] = busy[raddr[j]] exactly.
  - No combinational path from write ports to rdata/rbusy.

Decomposition:
- Shared package ysyx_23060286_rf_pkg holds:
  - XLEN and NREG defaults.
  - REG_ZERO = 0 constant.
  - A helper function for the highest-index-wins write select, reused by the bypass mux and the write logic.
- One natural sub-module, ysyx_23060286_rf_scoreboard: the busy bit array, its set/clear priority, and the rbusy lookup. Storage and the read/bypass muxing stay in the top.

Test Plan:
- Reset: write rf[5] = 0x1234 and set busy[5]; pulse rst_n low mid-cycle → rdata for raddr 5 = 0 immediately; busy_vec = 0.
- x0: wen[0] = 1, waddr = 0, wdata = 0xDEADBEEF; next cycle read raddr 0 → rdata = 0; issue_en with issue_addr 0 → busy_vec[0] = 0.
- Collision: port0 writes 0x11 and port1 writes 0x22 to reg 7 in the same cycle → next cycle rdata = 0x22.
- Scoreboard: issue reg 9 → rbusy = 1 from the next cycle. Later, issue reg 9 and write reg 9 in the same cycle → busy stays 1. The following cycle, write only → busy = 0.
- Bypass: write reg 3 = 0xCAFE while raddr[1] = 3.
  - With YSYX_23060286_RF_BYPASS_EN: rdata[1] = 0xCAFE in the same cycle; rbusy[1] = 0.
  - Without: rdata[1] = old value, then 0xCAFE the next cycle.
- Parameter sweep: NRD = 4, NWR = 3, NREG = 64, XLEN = 64. Random writes and reads against a reference model, 10k cycles, zero mismatches.
